// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide controller.
//   state_t         : 2-bit controller state encoding
//   DRAIN_CYC_DEF   : default number of cycles div_abandon is held after a flush
//   BUSY_SAT        : saturation value of the busy-cycle counter
package div_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DONE  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam int         DRAIN_CYC_DEF = 2;
   localparam logic [7:0] BUSY_SAT      = 8'hFF;

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for a multi-cycle DIV/DIVU unit.
// Latches operands, holds the pipeline while the divider runs, presents
// {hi, lo} until EX advances, and drains the divider after a flush.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   ex_div_req, ex_signed      divide valid in EX, 1 = signed
//   ex_opr1, ex_opr2           dividend, divisor
//   ex_advance, flush          EX hands off to MEM / EX killed
//   div_start, div_abandon     divider control
//   div_signed, div_opr1/2     latched operation to the divider
//   div_ready, div_res         divider done, {remainder, quotient}
//   stall_req                  pipeline hold (combinational)
//   res_valid, hi, lo          result: hi = remainder, lo = quotient
//   busy_cycles                saturating cycles spent in BUSY
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | no divide in flight, waiting for ex_div_req
// ST_BUSY  | divider running, div_start held, operands stable
// ST_DONE  | result held on hi/lo with res_valid until EX advances
// ST_DRAIN | flushed; div_abandon held for DRAIN_CYC cycles
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_div_req,
   input  logic        ex_signed,
   input  logic [31:0] ex_opr1,
   input  logic [31:0] ex_opr2,
   input  logic        ex_advance,
   input  logic        flush,
   output logic        div_start,
   output logic        div_abandon,
   output logic        div_signed,
   output logic [31:0] div_opr1,
   output logic [31:0] div_opr2,
   input  logic        div_ready,
   input  logic [63:0] div_res,
   output logic        stall_req,
   output logic        res_valid,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [7:0]  busy_cycles
);

   state_t     state;
   logic [7:0] drain_cnt;

   // Released in DONE so EX can advance with the held result.
   assign stall_req = ex_div_req & (state != ST_DONE) & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         div_start   <= 1'b0;
         div_abandon <= 1'b0;
         div_signed  <= 1'b0;
         div_opr1    <= '0;
         div_opr2    <= '0;
         res_valid   <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         busy_cycles <= '0;
         drain_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ex_div_req && !flush) begin
                  div_opr1    <= ex_opr1;
                  div_opr2    <= ex_opr2;
                  div_signed  <= ex_signed;
                  div_start   <= 1'b1;
                  busy_cycles <= '0;
                  state       <= ST_BUSY;
               end
            end

            ST_BUSY: begin
               if (busy_cycles != BUSY_SAT)
                  busy_cycles <= busy_cycles + 8'd1;
               // Flush wins over a same-cycle div_ready; that result is dropped.
               if (flush) begin
                  div_start   <= 1'b0;
                  div_abandon <= 1'b1;
                  drain_cnt   <= 8'(DRAIN_CYC);
                  state       <= ST_DRAIN;
               end else if (div_ready) begin
                  hi        <= div_res[63:32];
                  lo        <= div_res[31:0];
                  div_start <= 1'b0;
                  res_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (ex_advance || flush) begin
                  res_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end

            ST_DRAIN: begin
               // Leaving on the count that would reach zero keeps div_abandon
               // high for exactly DRAIN_CYC cycles.
               if (drain_cnt <= 8'd1) begin
                  drain_cnt   <= '0;
                  div_abandon <= 1'b0;
                  state       <= ST_IDLE;
               end else begin
                  drain_cnt <= drain_cnt - 8'd1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
   import div_ctrl_pkg::*;

   localparam int DIV_LAT = 34;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_div_req;
   logic        ex_signed;
   logic [31:0] ex_opr1;
   logic [31:0] ex_opr2;
   logic        ex_advance;
   logic        flush;
   logic        div_start;
   logic        div_abandon;
   logic        div_signed;
   logic [31:0] div_opr1;
   logic [31:0] div_opr2;
   logic        div_ready = 1'b0;
   logic [63:0] div_res = '0;
   logic        stall_req;
   logic        res_valid;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [7:0]  busy_cycles;

   int total = 0;
   int bad   = 0;
   int mcnt  = 0;

   always #5 clk = ~clk;

   div_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ex_div_req (ex_div_req),
      .ex_signed  (ex_signed),
      .ex_opr1    (ex_opr1),
      .ex_opr2    (ex_opr2),
      .ex_advance (ex_advance),
      .flush      (flush),
      .div_start  (div_start),
      .div_abandon(div_abandon),
      .div_signed (div_signed),
      .div_opr1   (div_opr1),
      .div_opr2   (div_opr2),
      .div_ready  (div_ready),
      .div_res    (div_res),
      .stall_req  (stall_req),
      .res_valid  (res_valid),
      .hi         (hi),
      .lo         (lo),
      .busy_cycles(busy_cycles)
   );

   // Behavioural divider: DIV_LAT cycles, 1 cycle for a zero divisor (zero result).
   always @(negedge clk) begin
      if (!rst_n || div_abandon || !div_start) begin
         mcnt      = 0;
         div_ready = 1'b0;
         div_res   = '0;
      end else begin
         mcnt++;
         if (mcnt >= ((div_opr2 == 32'd0) ? 1 : DIV_LAT)) begin
            div_ready = 1'b1;
            if (div_opr2 == 32'd0)
               div_res = '0;
            else if (div_signed)
               div_res = {32'($signed(div_opr1) % $signed(div_opr2)),
                          32'($signed(div_opr1) / $signed(div_opr2))};
            else
               div_res = {div_opr1 % div_opr2, div_opr1 / div_opr2};
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, 64'({div_start, div_abandon, div_signed, res_valid, stall_req}), 64'd0);
      chk({tag, "_opr"}, {div_opr1, div_opr2}, 64'd0);
      chk({tag, "_hilo"}, {hi, lo}, 64'd0);
      chk({tag, "_busy"}, 64'(busy_cycles), 64'd0);
      chk({tag, "_state"}, 64'(dut.state), 64'(ST_IDLE));
   endtask

   task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      ex_div_req = 1'b1;
      ex_signed  = sgn;
      ex_opr1    = a;
      ex_opr2    = b;
      #1;
      chk("stall_on_req", 64'(stall_req), 64'd1);
      tick();
      chk("issue_start", 64'(div_start), 64'd1);
      chk("issue_opr", {div_opr1, div_opr2}, {a, b});
      chk("issue_signed", 64'(div_signed), 64'(sgn));
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      while (!res_valid && n < max) begin
         chk("stall_busy", 64'(stall_req), 64'd1);
         tick();
         n++;
      end
      chk("done_in_time", 64'(res_valid), 64'd1);
      chk("stall_done", 64'(stall_req), 64'd0);
      chk("start_done", 64'(div_start), 64'd0);
   endtask

   task automatic retire();
      ex_advance = 1'b1;
      tick();
      ex_advance = 1'b0;
      ex_div_req = 1'b0;
      chk("retire_valid", 64'(res_valid), 64'd0);
      chk("retire_state", 64'(dut.state), 64'(ST_IDLE));
      tick();
      chk("no_reissue", 64'(div_start), 64'd0);
   endtask

   initial begin
      int n_ab;
      bit rv_seen;

      rst_n      = 1'b0;
      ex_div_req = 1'b0;
      ex_signed  = 1'b0;
      ex_opr1    = '0;
      ex_opr2    = '0;
      ex_advance = 1'b0;
      flush      = 1'b0;
      #12;
      chk_all_zero("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // DIVU 100/7 with DONE held for 5 cycles
      issue(1'b0, 32'd100, 32'd7);
      wait_done(60);
      chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});
      chk("divu_busy", 64'(busy_cycles), 64'd34);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_valid", 64'(res_valid), 64'd1);
         chk("hold_hilo", {hi, lo}, {32'd2, 32'd14});
         chk("hold_start", 64'(div_start), 64'd0);
      end
      retire();

      // DIV -7/2
      issue(1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_done(60);
      chk("div_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      retire();

      // DIVU by zero
      issue(1'b0, 32'd55, 32'd0);
      wait_done(10);
      chk("dz_hilo", {hi, lo}, 64'd0);
      chk("dz_busy_lt5", 64'(busy_cycles < 8'd5), 64'd1);
      chk("dz_busy", 64'(busy_cycles), 64'd1);
      retire();

      // flush at BUSY cycle 10, then a fresh 100/7
      issue(1'b0, 32'd100, 32'd7);
      repeat (10) tick();
      chk("flush_busy10", 64'(busy_cycles), 64'd10);
      flush = 1'b1;
      #1;
      chk("flush_stall", 64'(stall_req), 64'd0);
      tick();
      flush      = 1'b0;
      ex_div_req = 1'b0;
      chk("flush_abandon", 64'(div_abandon), 64'd1);
      chk("flush_start", 64'(div_start), 64'd0);
      chk("flush_state", 64'(dut.state), 64'(ST_DRAIN));
      n_ab    = 1;
      rv_seen = res_valid;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (res_valid) rv_seen = 1'b1;
         if (div_abandon) n_ab++;
         else break;
      end
      chk("abandon_cycles", 64'(n_ab), 64'd2);
      chk("flush_no_valid", 64'(rv_seen), 64'd0);
      chk("drain_idle", 64'(dut.state), 64'(ST_IDLE));
      issue(1'b0, 32'd100, 32'd7);
      wait_done(60);
      chk("postflush_hilo", {hi, lo}, {32'd2, 32'd14});
      retire();

      // flush coinciding with div_ready (zero divisor answers after 1 cycle)
      issue(1'b0, 32'd9, 32'd0);
      chk("prio_ready", 64'(div_ready), 64'd1);
      flush = 1'b1;
      tick();
      flush      = 1'b0;
      ex_div_req = 1'b0;
      chk("prio_valid", 64'(res_valid), 64'd0);
      chk("prio_state", 64'(dut.state), 64'(ST_DRAIN));
      tick();
      tick();
      chk("prio_idle", {62'd0, div_abandon, 1'b0} | 64'(dut.state), 64'(ST_IDLE));

      // reset mid-BUSY
      issue(1'b0, 32'd100, 32'd7);
      repeat (5) tick();
      ex_div_req = 1'b0;
      rst_n      = 1'b0;
      #1;
      chk_all_zero("midrst");
      tick();
      rst_n = 1'b1;
      tick();
      issue(1'b0, 32'd100, 32'd7);
      wait_done(60);
      chk("postrst_hilo", {hi, lo}, {32'd2, 32'd14});
      retire();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
